// File: rtl/axis_pkt_fifo.sv
// AXI-Stream beat FIFO; AXIS_PKT_FIFO_STORE_FWD_EN selects store-and-forward, otherwise cut-through.
// Latency: a pushed beat reaches m_* the cycle after its push edge (no combinational pass-through).
// Backpressure: s_tready drops when full, from registered state only; outputs hold while m_tready is low.
module axis_pkt_fifo #(
  parameter int TDATA_WIDTH = 4,
  parameter int TUSER_WIDTH = 1,
  parameter int DEPTH       = 8
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       s_tvalid,
  output logic                       s_tready,
  input  logic [TDATA_WIDTH*8-1:0]   s_tdata,
  input  logic [TDATA_WIDTH-1:0]     s_tkeep,
  input  logic                       s_tlast,
  input  logic [TUSER_WIDTH-1:0]     s_tuser,
  output logic                       m_tvalid,
  input  logic                       m_tready,
  output logic [TDATA_WIDTH*8-1:0]   m_tdata,
  output logic [TDATA_WIDTH-1:0]     m_tkeep,
  output logic                       m_tlast,
  output logic [TUSER_WIDTH-1:0]     m_tuser,
  output logic [$clog2(DEPTH):0]     level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  typedef struct packed {
    logic [TDATA_WIDTH*8-1:0] data;
    logic [TDATA_WIDTH-1:0]   keep;
    logic                     last;
    logic [TUSER_WIDTH-1:0]   user;
  } beat_t;

  beat_t          mem [DEPTH];
  beat_t          wr_beat;
  beat_t          rd_beat;
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;
  logic [LW-1:0]  level_q;
  logic           rdy_en;
  logic           full;
  logic           push;
  logic           pop;

  // rdy_en keeps s_tready low while in reset and raises it one edge after release.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) rdy_en <= 1'b0;
    else          rdy_en <= 1'b1;
  end

  assign full     = (level_q == LW'(DEPTH));
  assign s_tready = rdy_en && !full;
  assign push     = s_tvalid && s_tready;
  assign pop      = m_tvalid && m_tready;
  assign level    = level_q;

  assign wr_beat = '{data: s_tdata, keep: s_tkeep, last: s_tlast, user: s_tuser};
  assign rd_beat = mem[rd_ptr];
  assign m_tdata = rd_beat.data;
  assign m_tkeep = rd_beat.keep;
  assign m_tlast = rd_beat.last;
  assign m_tuser = rd_beat.user;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_beat;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level_q <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   level_q <= level_q + LW'(1);
        2'b01:   level_q <= level_q - LW'(1);
        default: level_q <= level_q;
      endcase
    end
  end

`ifdef AXIS_PKT_FIFO_STORE_FWD_EN
  logic [LW-1:0] pkt_cnt;
  logic          pkt_inc;
  logic          pkt_dec;

  assign pkt_inc = push && s_tlast;
  assign pkt_dec = pop && m_tlast;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pkt_cnt <= '0;
    end else begin
      case ({pkt_inc, pkt_dec})
        2'b10:   pkt_cnt <= pkt_cnt + LW'(1);
        2'b01:   pkt_cnt <= pkt_cnt - LW'(1);
        default: pkt_cnt <= pkt_cnt;
      endcase
    end
  end

  // A full FIFO forwards regardless, so packets longer than DEPTH cannot deadlock.
  assign m_tvalid = (level_q != '0) && ((pkt_cnt != '0) || full);
`else
  assign m_tvalid = (level_q != '0);
`endif

endmodule

// File: tb/tb_axis_pkt_fifo.sv
// Directed bench for axis_pkt_fifo at DEPTH=4, TDATA_WIDTH=4; expectations follow the build mode.
module tb_axis_pkt_fifo;

`ifdef AXIS_PKT_FIFO_STORE_FWD_EN
  localparam bit SF = 1'b1;
`else
  localparam bit SF = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset_n;
  logic        s_tvalid;
  logic        s_tready;
  logic [31:0] s_tdata;
  logic [3:0]  s_tkeep;
  logic        s_tlast;
  logic [0:0]  s_tuser;
  logic        m_tvalid;
  logic        m_tready;
  logic [31:0] m_tdata;
  logic [3:0]  m_tkeep;
  logic        m_tlast;
  logic [0:0]  m_tuser;
  logic [2:0]  level;

  int checks = 0;
  int passes = 0;
  int fails  = 0;

  axis_pkt_fifo #(.TDATA_WIDTH(4), .TUSER_WIDTH(1), .DEPTH(4)) dut (
    .clk(clk), .reset_n(reset_n),
    .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tdata(s_tdata),
    .s_tkeep(s_tkeep), .s_tlast(s_tlast), .s_tuser(s_tuser),
    .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tdata(m_tdata),
    .m_tkeep(m_tkeep), .m_tlast(m_tlast), .m_tuser(m_tuser),
    .level(level)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] d, input logic [3:0] k,
                       input logic l, input logic u);
    s_tvalid = v;
    s_tdata  = d;
    s_tkeep  = k;
    s_tlast  = l;
    s_tuser  = u;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation bound expired");
    $fatal(1, "timeout");
  end

  initial begin
    int tx;
    int rx;
    int first_lvl;
    logic p_push;

    reset_n  = 1'b1;
    m_tready = 1'b0;
    drive(1'b0, 32'h0, 4'h0, 1'b0, 1'b0);
    #1 reset_n = 1'b0;
    #1;
    chk("rst_s_tready", 64'(s_tready), 64'(0));
    chk("rst_m_tvalid", 64'(m_tvalid), 64'(0));
    chk("rst_level",    64'(level),    64'(0));
    @(posedge clk);
    @(posedge clk);
    #1 reset_n = 1'b1;
    chk("rel_s_tready_low", 64'(s_tready), 64'(0));
    tick();
    chk("rel_s_tready_high", 64'(s_tready), 64'(1));
    chk("rel_m_tvalid",      64'(m_tvalid), 64'(0));

    // single beat round trip
    m_tready = 1'b1;
    drive(1'b1, 32'h11111111, 4'hF, 1'b1, 1'b0);
    tick();
    drive(1'b0, 32'h0, 4'h0, 1'b0, 1'b0);
    chk("one_m_tvalid", 64'(m_tvalid), 64'(1));
    chk("one_m_tdata",  64'(m_tdata),  64'(32'h11111111));
    chk("one_level",    64'(level),    64'(1));
    tick();
    chk("one_level_drain", 64'(level),    64'(0));
    chk("one_m_tvalid_0",  64'(m_tvalid), 64'(0));

    // fill to full with sink stalled, 5th beat waits for a pop
    m_tready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 32'hA0 + 32'(i), 4'hF, 1'b0, 1'b0);
      chk("fill_s_tready", 64'(s_tready), 64'(1));
      tick();
    end
    chk("full_level",    64'(level),    64'(4));
    chk("full_s_tready", 64'(s_tready), 64'(0));
    drive(1'b1, 32'hA4, 4'h0, 1'b1, 1'b1);
    chk("full_m_tvalid", 64'(m_tvalid), 64'(1));
    chk("full_head",     64'(m_tdata),  64'(32'hA0));
    tick();
    chk("full_hold_level", 64'(level),   64'(4));
    chk("full_hold_head",  64'(m_tdata), 64'(32'hA0));
    m_tready = 1'b1;
    tick();
    chk("pop_full_level",    64'(level),    64'(3));
    chk("pop_full_s_tready", 64'(s_tready), 64'(1));
    chk("pop_full_head",     64'(m_tdata),  64'(32'hA1));
    m_tready = 1'b0;
    tick();
    chk("late_push_level", 64'(level), 64'(4));
    drive(1'b0, 32'h0, 4'h0, 1'b0, 1'b0);
    m_tready = 1'b1;
    for (int i = 1; i < 5; i++) begin
      chk("drain_m_tvalid", 64'(m_tvalid), 64'(1));
      chk("drain_m_tdata",  64'(m_tdata),  64'(32'hA0 + 32'(i)));
      if (i == 4) begin
        chk("zero_keep_fwd", 64'(m_tkeep), 64'(0));
        chk("zero_keep_last", 64'(m_tlast), 64'(1));
        chk("zero_keep_user", 64'(m_tuser), 64'(1));
      end
      tick();
    end
    chk("drain_level",    64'(level),    64'(0));
    chk("drain_m_tvalid", 64'(m_tvalid), 64'(0));

    // streaming at one beat per cycle
    for (int i = 0; i < 20; i++) begin
      drive(1'b1, 32'h100 + 32'(i), 4'hF, 1'b1, 1'b0);
      tick();
      chk("stream_m_tvalid", 64'(m_tvalid), 64'(1));
      chk("stream_m_tdata",  64'(m_tdata),  64'(32'h100 + 32'(i)));
      chk("stream_level",    64'(level),    64'(1));
    end
    drive(1'b0, 32'h0, 4'h0, 1'b0, 1'b0);
    tick();
    chk("stream_end_level", 64'(level), 64'(0));

    // three-beat packet with tlast on the final beat
    m_tready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'hB0 + 32'(i), 4'hF, (i == 2), 1'b0);
      tick();
      chk("pkt3_level",    64'(level),    64'(i + 1));
      chk("pkt3_m_tvalid", 64'(m_tvalid), 64'(SF ? (i == 2) : 1'b1));
    end
    drive(1'b0, 32'h0, 4'h0, 1'b0, 1'b0);
    m_tready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk("pkt3_out_vld", 64'(m_tvalid), 64'(1));
      chk("pkt3_out_dat", 64'(m_tdata),  64'(32'hB0 + 32'(i)));
      tick();
    end
    chk("pkt3_level_end", 64'(level), 64'(0));

    // six-beat packet longer than the FIFO
    tx = 0;
    rx = 0;
    first_lvl = -1;
    drive(1'b1, 32'hC0, 4'hF, 1'b0, 1'b0);
    for (int cyc = 0; cyc < 40 && rx < 6; cyc++) begin
      if (m_tvalid && first_lvl < 0) first_lvl = int'(level);
      p_push = s_tvalid && s_tready;
      if (m_tvalid && m_tready) begin
        chk("pkt6_data", 64'(m_tdata), 64'(32'hC0 + 32'(rx)));
        rx++;
      end
      if (p_push) tx++;
      tick();
      if (tx < 6) drive(1'b1, 32'hC0 + 32'(tx), 4'hF, (tx == 5), 1'b0);
      else        drive(1'b0, 32'h0, 4'h0, 1'b0, 1'b0);
    end
    chk("pkt6_count",      64'(rx),        64'(6));
    chk("pkt6_first_lvl",  64'(first_lvl), 64'(SF ? 4 : 1));
    chk("pkt6_level_end",  64'(level),     64'(0));

    // reset while a partial packet is stored
    m_tready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'hD0 + 32'(i), 4'hF, 1'b0, 1'b0);
      tick();
    end
    drive(1'b0, 32'h0, 4'h0, 1'b0, 1'b0);
    chk("mid_level", 64'(level), 64'(3));
    #2 reset_n = 1'b0;
    #1;
    chk("mid_rst_m_tvalid", 64'(m_tvalid), 64'(0));
    chk("mid_rst_level",    64'(level),    64'(0));
    chk("mid_rst_s_tready", 64'(s_tready), 64'(0));
    m_tready = 1'b1;
    tick();
    reset_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("post_rst_no_beat", 64'(m_tvalid), 64'(0));
    end
    chk("post_rst_s_tready", 64'(s_tready), 64'(1));
    chk("post_rst_level",    64'(level),    64'(0));

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/axis_pkt_fifo.md
AXIS_PKT_FIFO -- requirements
Module: axis_pkt_fifo

Interface
REQ-001 Parameter TDATA_WIDTH, default 4: data width in bytes; tdata is TDATA_WIDTH*8 bits.
REQ-002 Parameter TUSER_WIDTH, default 1: tuser width in bits.
REQ-003 Parameter DEPTH, default 8: storage entries; SHALL be a power of 2, minimum 2.
REQ-004 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-005 reset_n  input  1  reset, asynchronous assert, active-low.
REQ-006 s_tvalid  input  1  slave-side beat valid.
REQ-007 s_tready  output  1  slave-side ready.
REQ-008 s_tdata  input  TDATA_WIDTH*8  slave-side data.
REQ-009 s_tkeep  input  TDATA_WIDTH  slave-side byte-keep.
REQ-010 s_tlast  input  1  slave-side end of packet.
REQ-011 s_tuser  input  TUSER_WIDTH  slave-side sideband.
REQ-012 m_tvalid  output  1  master-side beat valid.
REQ-013 m_tready  input  1  master-side ready.
REQ-014 m_tdata / m_tkeep / m_tlast / m_tuser  output  same widths as s_*  master-side beat fields, one port each.
REQ-015 level  output  $clog2(DEPTH)+1  number of stored beats.

Function
REQ-016 Push SHALL occur on a rising edge with s_tvalid && s_tready; pop SHALL occur with m_tvalid && m_tready.
REQ-017 s_tready SHALL equal (level != DEPTH), combinational from registered state only, never from s_tvalid or m_tready.
REQ-018 The FIFO SHALL have no combinational pass-through: a beat pushed at edge N SHALL be visible on m_* no earlier than the cycle after edge N.
REQ-019 m_tdata/m_tkeep/m_tlast/m_tuser SHALL present the oldest stored beat whenever m_tvalid is 1, and SHALL hold stable while m_tvalid && !m_tready.
REQ-020 Beats SHALL leave in push order, with all fields unmodified.
REQ-021 Write and read pointers SHALL be $clog2(DEPTH) bits and wrap from DEPTH-1 to 0.
REQ-022 level: +1 on push only, -1 on pop only, unchanged on simultaneous push and pop.
REQ-023 Full (level == DEPTH): s_tready is 0. A pop at the same edge SHALL NOT admit a beat; s_tready rises the following cycle.
REQ-024 Empty (level == 0): m_tvalid is 0. A push SHALL yield m_tvalid 1 the next cycle.
REQ-025 At level 1 with simultaneous push and pop, the pushed beat SHALL be presented the next cycle with m_tvalid continuously 1.
REQ-026 Sustained throughput SHALL be one beat per cycle when neither side stalls.
REQ-027 The block SHALL NOT interpret tkeep contents; beats with tkeep all-zero SHALL be stored and forwarded like any other beat.

Reset
REQ-028 Asserting reset_n low SHALL immediately clear pointers, level and all counters, and drive s_tready 0 and m_tvalid 0.
REQ-029 s_tready SHALL rise the first cycle after reset_n deasserts; storage contents need not be reset.
REQ-030 Reset mid-packet SHALL discard all stored beats, including partial packets, with no beat emitted afterwards.

Configuration
REQ-031 Macro AXIS_PKT_FIFO_STORE_FWD_EN defined: store-and-forward mode. Adds an internal pkt_cnt ($clog2(DEPTH)+1 bits): +1 on push with s_tlast, -1 on pop with m_tlast, unchanged when both occur. m_tvalid SHALL equal (level != 0) && (pkt_cnt != 0 || level == DEPTH). The full override prevents deadlock on packets longer than DEPTH.
REQ-032 Macro not defined: cut-through mode. m_tvalid SHALL equal (level != 0), and no pkt_cnt logic is generated.

Verification (DEPTH=4, TDATA_WIDTH=4)
REQ-033 Reset then push 0x11111111 with tlast=1 and m_tready=1 -> m_tvalid 1 exactly one cycle later with m_tdata 0x11111111, level returns to 0.
REQ-034 m_tready=0, push 5 beats -> first 4 accepted, s_tready 0 and level 4. Pop one with a 5th pending -> 5th accepted one cycle after the pop.
REQ-035 Continuous push and pop for 20 beats of incrementing data -> 20 beats out in order, level constant at 1 after fill, no m_tvalid gap.
REQ-036 STORE_FWD_EN: push 3 beats with tlast only on the 3rd -> m_tvalid 0 until the cycle after the 3rd push, then 3 beats in order.
REQ-037 STORE_FWD_EN: push a 6-beat packet with m_tready=1 -> m_tvalid rises when level hits 4 (full override), and all 6 beats are delivered.
REQ-038 Assert reset_n low with level 3 mid-packet -> same-cycle m_tvalid 0 and level 0, and no stale beat after release.
